// File: rtl/stock_moving_avg_pkg.sv
// Shared definitions for the stock moving-average block: FSM state
// encoding, default sample width and the running-sum width helper.
package stock_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32'd32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        UPDATE = 2'd2,
        OUT    = 2'd3
    } mavg_state_t;

    // A window of 2**win_log2 samples needs win_log2 extra bits so the
    // running sum can never wrap.
    function automatic int unsigned sum_width(input int unsigned data_w,
                                              input int unsigned win_log2);
        return data_w + win_log2;
    endfunction

endpackage

// File: rtl/stock_moving_avg_if.sv
// Price-stream interface of the moving-average block. The master side
// feeds samples and flush requests; the slave side (the averager)
// returns the average and its status flags.
interface stock_moving_avg_if
    import stock_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

    logic [DATA_W-1:0] stock_price;
    logic              data_ready;
    logic              clear;
    logic [DATA_W-1:0] average;
    logic              avg_valid;
    logic              window_full;
    logic              busy;
    logic              overrun;

    modport master (
        output stock_price, data_ready, clear,
        input  average, avg_valid, window_full, busy, overrun
    );

    modport slave (
        input  stock_price, data_ready, clear,
        output average, avg_valid, window_full, busy, overrun
    );

endinterface

// File: rtl/stock_moving_avg_ring_buf.sv
// Single-port register-file ring buffer holding the sample window.
// Synchronous read, write enable, external address; kept separate so the
// storage can later be swapped for an on-chip SRAM wrapper. Contents are
// not reset: entries are only ever read back once they have been written.
module mavg_ring_buf
    import stock_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned WIN_LOG2 = 32'd5
) (
    input  logic                clk,
    input  logic [WIN_LOG2-1:0] addr,
    input  logic                we,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem_r [0:(32'd1 << WIN_LOG2) - 32'd1];
    logic [DATA_W-1:0] rdata_r;

    // Storage write and registered read of the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/stock_moving_avg.sv
// Sliding-window moving average of a stock price stream.
// Each accepted sample walks IDLE -> READ -> UPDATE -> OUT: the oldest
// entry is read, the running sum is adjusted (add newest, subtract
// evicted once the window is full), the newest sample overwrites the
// oldest, and the average (sum >> WIN_LOG2) is registered.
// Optional build macro STOCK_MAVG_ROUND_EN: round-half-up averaging with
// clamping to the largest sample value; otherwise plain truncation.
module stock_moving_avg
    import stock_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned WIN_LOG2 = 32'd5
) (
    input  logic              clk,
    input  logic              n_rst,
    stock_moving_avg_if.slave bus
);

    localparam int unsigned SUM_W = sum_width(DATA_W, WIN_LOG2);
    localparam int unsigned CNT_W = WIN_LOG2 + 32'd1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(32'd1 << WIN_LOG2);

    mavg_state_t          state_r;
    mavg_state_t          state_s;
    logic [DATA_W-1:0]    price_r;
    logic [SUM_W-1:0]     sum_r;
    logic [CNT_W-1:0]     count_r;
    logic [WIN_LOG2-1:0]  wr_ptr_r;
    logic [DATA_W-1:0]    average_r;
    logic                 avg_valid_r;
    logic                 window_full_r;
    logic                 busy_r;
    logic                 overrun_r;

    logic [DATA_W-1:0]    old_s;
    logic [SUM_W-1:0]     evict_s;
    logic [SUM_W-1:0]     sum_upd_s;
    logic [CNT_W-1:0]     count_upd_s;
    logic [DATA_W-1:0]    avg_s;
    logic                 buf_we_s;
    logic                 buf_re_s;
`ifdef STOCK_MAVG_ROUND_EN
    logic [SUM_W:0]       round_s;
    logic [SUM_W:0]       round_shift_s;
`endif

    // The buffer is read while in READ and written while in UPDATE, both
    // at the write pointer, which always addresses the oldest entry.
    assign buf_re_s = (state_r == READ);
    assign buf_we_s = (state_r == UPDATE) && !bus.clear;

    mavg_ring_buf #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_ring_buf (
        .clk   (clk),
        .addr  (wr_ptr_r),
        .we    (buf_we_s),
        .wdata (price_r),
        .re    (buf_re_s),
        .rdata (old_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a flush always returns to IDLE.
    always_comb begin
        state_s = state_r;
        if (bus.clear) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.data_ready) begin
                        state_s = READ;
                    end else begin
                        state_s = IDLE;
                    end
                end
                READ:    state_s = UPDATE;
                UPDATE:  state_s = OUT;
                OUT:     state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Running-sum and fill-count updates applied in UPDATE.
    always_comb begin
        evict_s     = {SUM_W{1'b0}};
        count_upd_s = count_r;
        if (window_full_r) begin
            evict_s = SUM_W'(old_s);
        end else begin
            evict_s = {SUM_W{1'b0}};
        end
        sum_upd_s = sum_r + SUM_W'(price_r) - evict_s;
        if (count_r == DEPTH) begin
            count_upd_s = count_r;
        end else begin
            count_upd_s = count_r + CNT_W'(1'b1);
        end
    end

    // Average of the current sum: truncating, or rounded half-up and clamped.
    always_comb begin
        avg_s = {DATA_W{1'b0}};
`ifdef STOCK_MAVG_ROUND_EN
        round_s       = {1'b0, sum_r} + ({{SUM_W{1'b0}}, 1'b1} << (WIN_LOG2 - 32'd1));
        round_shift_s = round_s >> WIN_LOG2;
        if (round_shift_s > {{(SUM_W + 32'd1 - DATA_W){1'b0}}, {DATA_W{1'b1}}}) begin
            avg_s = {DATA_W{1'b1}};
        end else begin
            avg_s = round_shift_s[DATA_W-1:0];
        end
`else
        avg_s = DATA_W'(sum_r >> WIN_LOG2);
`endif
    end

    // Datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            price_r       <= {DATA_W{1'b0}};
            sum_r         <= {SUM_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            wr_ptr_r      <= {WIN_LOG2{1'b0}};
            average_r     <= {DATA_W{1'b0}};
            avg_valid_r   <= 1'b0;
            window_full_r <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
        end else if (bus.clear) begin
            sum_r         <= {SUM_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            wr_ptr_r      <= {WIN_LOG2{1'b0}};
            average_r     <= {DATA_W{1'b0}};
            avg_valid_r   <= 1'b0;
            window_full_r <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            avg_valid_r <= 1'b0;
            overrun_r   <= bus.data_ready && (state_r != IDLE);
            busy_r      <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (bus.data_ready) begin
                        price_r <= bus.stock_price;
                    end
                end
                UPDATE: begin
                    sum_r         <= sum_upd_s;
                    count_r       <= count_upd_s;
                    window_full_r <= (count_upd_s == DEPTH);
                    wr_ptr_r      <= wr_ptr_r + WIN_LOG2'(1'b1);
                end
                OUT: begin
                    average_r   <= avg_s;
                    avg_valid_r <= window_full_r;
                end
                default: begin
                    avg_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.average     = average_r;
    assign bus.avg_valid   = avg_valid_r;
    assign bus.window_full = window_full_r;
    assign bus.busy        = busy_r;
    assign bus.overrun     = overrun_r;

endmodule
